mem_access_unit: RTL and testbench

MEM-stage controller on the output side of the EX/MEM pipeline register. Consumes the MEM-stage control and data fields, runs a request/acknowledge transaction to a variable-latency data memory, and freezes upstream stages with `mem_stall` until the access completes. Produces the registered MEM/WB fields (write-enable, target register, write-back data). A timeout counter aborts hung accesses and raises a sticky bus error.

---
 rtl/mem_pkg.sv | 13 +
 rtl/timeout_counter.sv | 29 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state type and widths for the MEM-stage data-memory access controller.
package mem_pkg;

   localparam int DATA_W = 64;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/timeout_counter.sv
// Counts WAIT cycles without an acknowledge; tc flags the cycle in which the
// count has reached TIMEOUT-1, i.e. the last cycle an ack can still complete.
module timeout_counter
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_p1 <= '0;
      end else if (clr) begin
         cnt_p1 <= '0;
      end else if (en) begin
         cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
   end

   assign tc = (cnt_p1 == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs req/ack transactions to a variable-latency data
// memory, stalls upstream while busy, and produces the registered MEM/WB fields.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead_MEM,
   input  logic              memWrite_MEM,
   input  logic              memToReg_MEM,
   input  logic              RegWrite_MEM,
   input  logic              branchLink_MEM,
   input  logic [REG_W-1:0]  targetReg_MEM,
   input  logic [DATA_W-1:0] toDataMem_MEM,
   input  logic [DATA_W-1:0] rd2_MEM,
   input  logic [DATA_W-1:0] linkAddr_MEM,
   output logic              dm_req,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              mem_stall,
   output logic              RegWrite_WB,
   output logic [REG_W-1:0]  targetReg_WB,
   output logic [DATA_W-1:0] wbData_WB,
   output logic              bus_err
);

   mem_state_t        state_p1, state_nxt;
   logic              hold_we_p1, hold_we_nxt;
   logic [REG_W-1:0]  hold_tgt_p1, hold_tgt_nxt;
   logic              req_nxt, we_nxt, rw_nxt, err_nxt;
   logic [DATA_W-1:0] addr_nxt, wdata_nxt, wb_nxt;
   logic [REG_W-1:0]  tgt_nxt;
   logic              cnt_clr, cnt_en, cnt_tc;
   logic              access;

   assign access    = memRead_MEM | memWrite_MEM;
   assign mem_stall = ((state_p1 == IDLE) & access) | ((state_p1 == WAIT) & ~dm_ack);

   timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_nxt    = state_p1;
      req_nxt      = dm_req;
      we_nxt       = dm_we;
      addr_nxt     = dm_addr;
      wdata_nxt    = dm_wdata;
      hold_we_nxt  = hold_we_p1;
      hold_tgt_nxt = hold_tgt_p1;
      rw_nxt       = RegWrite_WB;
      tgt_nxt      = targetReg_WB;
      wb_nxt       = wbData_WB;
      err_nxt      = bus_err;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      case (state_p1)
         IDLE: begin
            if (access) begin
               // A read+write combination is treated as a store with no write-back.
               addr_nxt     = toDataMem_MEM;
               wdata_nxt    = rd2_MEM;
               we_nxt       = memWrite_MEM;
               hold_tgt_nxt = targetReg_MEM;
               hold_we_nxt  = RegWrite_MEM & memToReg_MEM & ~memWrite_MEM;
               req_nxt      = 1'b1;
               cnt_clr      = 1'b1;
               rw_nxt       = 1'b0;
               state_nxt    = WAIT;
            end else begin
               rw_nxt  = RegWrite_MEM;
               tgt_nxt = targetReg_MEM;
               wb_nxt  = branchLink_MEM ? linkAddr_MEM : toDataMem_MEM;
            end
         end
         WAIT: begin
            if (dm_ack) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
               if (dm_we) begin
                  rw_nxt = 1'b0;
               end else begin
                  rw_nxt  = hold_we_p1;
                  tgt_nxt = hold_tgt_p1;
                  wb_nxt  = dm_rdata;
               end
            end else begin
               cnt_en = 1'b1;
               rw_nxt = 1'b0;
               if (cnt_tc) begin
                  req_nxt   = 1'b0;
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request and hold registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_p1    <= IDLE;
         dm_req      <= 1'b0;
         dm_we       <= 1'b0;
         dm_addr     <= '0;
         dm_wdata    <= '0;
         hold_we_p1  <= 1'b0;
         hold_tgt_p1 <= '0;
         bus_err     <= 1'b0;
      end else begin
         state_p1    <= state_nxt;
         dm_req      <= req_nxt;
         dm_we       <= we_nxt;
         dm_addr     <= addr_nxt;
         dm_wdata    <= wdata_nxt;
         hold_we_p1  <= hold_we_nxt;
         hold_tgt_p1 <= hold_tgt_nxt;
         bus_err     <= err_nxt;
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite_WB  <= 1'b0;
         targetReg_WB <= '0;
         wbData_WB    <= '0;
      end else begin
         RegWrite_WB  <= rw_nxt;
         targetReg_WB <= tgt_nxt;
         wbData_WB    <= wb_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit, checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_access_unit;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead_MEM, memWrite_MEM, memToReg_MEM, RegWrite_MEM, branchLink_MEM;
   logic [4:0]  targetReg_MEM;
   logic [63:0] toDataMem_MEM, rd2_MEM, linkAddr_MEM;
   logic        dm_req, dm_we, dm_ack, mem_stall, RegWrite_WB, bus_err;
   logic [63:0] dm_addr, dm_wdata, dm_rdata, wbData_WB;
   logic [4:0]  targetReg_WB;

   mem_access_unit #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .memRead_MEM    (memRead_MEM),
      .memWrite_MEM   (memWrite_MEM),
      .memToReg_MEM   (memToReg_MEM),
      .RegWrite_MEM   (RegWrite_MEM),
      .branchLink_MEM (branchLink_MEM),
      .targetReg_MEM  (targetReg_MEM),
      .toDataMem_MEM  (toDataMem_MEM),
      .rd2_MEM        (rd2_MEM),
      .linkAddr_MEM   (linkAddr_MEM),
      .dm_req         (dm_req),
      .dm_we          (dm_we),
      .dm_addr        (dm_addr),
      .dm_wdata       (dm_wdata),
      .dm_ack         (dm_ack),
      .dm_rdata       (dm_rdata),
      .mem_stall      (mem_stall),
      .RegWrite_WB    (RegWrite_WB),
      .targetReg_WB   (targetReg_WB),
      .wbData_WB      (wbData_WB),
      .bus_err        (bus_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level model state
   bit          m_busy, m_we, m_rw, m_err, m_ld_we;
   int          m_waited;
   logic [63:0] m_addr, m_wdata, m_wb;
   logic [4:0]  m_tgt, m_ld_tgt;

   int          last_stall;
   logic        cap_we;
   logic [63:0] cap_addr, cap_wdata;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_we = 0; m_rw = 0; m_err = 0; m_ld_we = 0; m_waited = 0;
      m_addr = '0; m_wdata = '0; m_wb = '0; m_tgt = '0; m_ld_tgt = '0;
   endtask

   function automatic bit model_stall();
      return m_busy ? !dm_ack : (memRead_MEM || memWrite_MEM);
   endfunction

   task automatic model_update();
      if (!m_busy) begin
         if (memRead_MEM || memWrite_MEM) begin
            m_busy = 1; m_waited = 0;
            m_we = memWrite_MEM; m_addr = toDataMem_MEM; m_wdata = rd2_MEM;
            m_ld_we = RegWrite_MEM && memToReg_MEM && !memWrite_MEM;
            m_ld_tgt = targetReg_MEM;
            m_rw = 0;
         end else begin
            m_rw = RegWrite_MEM; m_tgt = targetReg_MEM;
            m_wb = branchLink_MEM ? linkAddr_MEM : toDataMem_MEM;
         end
      end else if (dm_ack) begin
         m_busy = 0;
         if (m_we) m_rw = 0;
         else begin
            m_rw = m_ld_we; m_tgt = m_ld_tgt; m_wb = dm_rdata;
         end
      end else begin
         m_waited++;
         m_rw = 0;
         if (m_waited == TIMEOUT) begin
            m_busy = 0; m_err = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("dm_req",       dm_req,       m_busy);
      check("dm_we",        dm_we,        m_we);
      check("dm_addr",      dm_addr,      m_addr);
      check("dm_wdata",     dm_wdata,     m_wdata);
      check("RegWrite_WB",  RegWrite_WB,  m_rw);
      check("targetReg_WB", targetReg_WB, m_tgt);
      check("wbData_WB",    wbData_WB,    m_wb);
      check("bus_err",      bus_err,      m_err);
   endtask

   // One clock: stall checked mid-cycle, registered outputs just after the edge.
   task automatic tick();
      @(negedge clk);
      last_stall = int'(mem_stall);
      check("mem_stall", mem_stall, model_stall());
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic set_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                            input logic bl, input logic [4:0] tgt, input logic [63:0] alu,
                            input logic [63:0] d2, input logic [63:0] lnk);
      memRead_MEM = rd; memWrite_MEM = wr; memToReg_MEM = m2r; RegWrite_MEM = rw;
      branchLink_MEM = bl; targetReg_MEM = tgt; toDataMem_MEM = alu; rd2_MEM = d2;
      linkAddr_MEM = lnk;
   endtask

   task automatic rand_instr();
      int r = int'($urandom_range(0, 9));
      set_instr(r inside {[4:6], 9}, r >= 7, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   // Issue the access currently on the inputs; ack is seen in the k-th WAIT cycle
   // (k outside 1..TIMEOUT means no ack, so the access times out).
   task automatic run_access(input int k, input logic [63:0] rdata,
                             output int stall_n, output int req_n);
      stall_n = 0; req_n = 0;
      dm_ack = 0; dm_rdata = {$urandom, $urandom};
      tick();
      stall_n += last_stall; req_n += int'(dm_req);
      cap_we = dm_we; cap_addr = dm_addr; cap_wdata = dm_wdata;
      for (int c = 1; c <= TIMEOUT + 2 && m_busy; c++) begin
         dm_ack   = (c == k);
         dm_rdata = (c == k) ? rdata : {$urandom, $urandom};
         tick();
         stall_n += last_stall; req_n += int'(dm_req);
      end
      dm_ack = 0;
      set_instr(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sn, rn;
      reset = 1'b0;
      dm_ack = 0; dm_rdata = '0;
      set_instr(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_dm_req", dm_req, 0);
      check("rst_RegWrite_WB", RegWrite_WB, 0);
      check("rst_wbData_WB", wbData_WB, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_mem_stall", mem_stall, 0);
      reset = 1'b1;

      // Non-memory instruction
      set_instr(0, 0, 0, 1, 0, 5'd20, 64'h1A4, 64'h77, 64'h999);
      tick();
      check("alu_wbData", wbData_WB, 64'h1A4);
      check("alu_RegWrite", RegWrite_WB, 1);
      check("alu_target", targetReg_WB, 20);
      check("alu_stall", last_stall, 0);

      // Branch-and-link selects the link address
      set_instr(0, 0, 0, 1, 1, 5'd31, 64'h1234, 64'h0, 64'h2000);
      tick();
      check("bl_wbData", wbData_WB, 64'h2000);

      // Load, ack in the third WAIT cycle
      set_instr(1, 0, 1, 1, 0, 5'd5, 64'h40, 64'h0, 64'h0);
      run_access(3, 64'd42069, sn, rn);
      check("ld_req_cycles", rn, 3);
      check("ld_stall_cycles", sn, 3);
      check("ld_addr", cap_addr, 64'h40);
      check("ld_wbData", wbData_WB, 64'd42069);
      check("ld_target", targetReg_WB, 5);
      check("ld_RegWrite", RegWrite_WB, 1);

      // Store, ack in the first WAIT cycle
      set_instr(0, 1, 0, 1, 0, 5'd6, 64'h80, 64'd420, 64'h0);
      run_access(1, 64'hDEAD, sn, rn);
      check("st_we", cap_we, 1);
      check("st_wdata", cap_wdata, 64'd420);
      check("st_addr", cap_addr, 64'h80);
      check("st_RegWrite", RegWrite_WB, 0);
      check("st_bus_err", bus_err, 0);
      check("st_stall_cycles", sn, 1);

      // Ack in the terminal-count cycle
      set_instr(1, 0, 1, 1, 0, 5'd9, 64'h100, 64'h0, 64'h0);
      run_access(TIMEOUT, 64'hBEEF, sn, rn);
      check("tc_wbData", wbData_WB, 64'hBEEF);
      check("tc_RegWrite", RegWrite_WB, 1);
      check("tc_bus_err", bus_err, 0);

      // Timeout with no ack
      set_instr(1, 0, 1, 1, 0, 5'd11, 64'h200, 64'h0, 64'h0);
      run_access(0, 64'h0, sn, rn);
      check("to_req_cycles", rn, TIMEOUT);
      check("to_bus_err", bus_err, 1);
      check("to_RegWrite", RegWrite_WB, 0);
      set_instr(0, 0, 0, 1, 0, 5'd7, 64'h55, 64'h0, 64'h0);
      tick();
      check("to_next_stall", last_stall, 0);
      check("to_next_wbData", wbData_WB, 64'h55);
      check("to_next_RegWrite", RegWrite_WB, 1);
      check("to_err_sticky", bus_err, 1);

      // Reset during WAIT, then a late ack
      set_instr(1, 0, 1, 1, 0, 5'd3, 64'h300, 64'h0, 64'h0);
      dm_ack = 0;
      tick();
      set_instr(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
      tick();
      #2 reset = 1'b0;
      #1;
      check("rw_dm_req", dm_req, 0);
      check("rw_RegWrite", RegWrite_WB, 0);
      check("rw_wbData", wbData_WB, 0);
      check("rw_target", targetReg_WB, 0);
      check("rw_bus_err", bus_err, 0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      dm_ack = 1; dm_rdata = 64'hCAFE;
      tick();
      dm_ack = 0;
      check("rw_late_ack_RegWrite", RegWrite_WB, 0);
      check("rw_late_ack_req", dm_req, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_instr();
         if (memRead_MEM || memWrite_MEM) begin
            run_access(int'($urandom_range(1, TIMEOUT + 1)), {$urandom, $urandom}, sn, rn);
         end else begin
            dm_ack   = ($urandom_range(0, 3) == 0);
            dm_rdata = {$urandom, $urandom};
            tick();
            dm_ack = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
